trng_health_mon: RTL
====================

TRNG_HEALTH_MON -- requirements
Module: trng_health_mon

Interface
REQ-001 SHALL have parameter RCT_CUTOFF, default 8: repetition-count limit, i.e. identical consecutive bits that declare failure.
REQ-002 SHALL have parameter APT_WINDOW, default 64: adaptive-proportion window length in valid bits.
REQ-003 SHALL have parameter APT_CUTOFF, default 48: matches within a window that declare failure.
REQ-004 SHALL have parameter STARTUP_BITS, default 128: valid bits that must pass before output is enabled.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_bit  input  1  raw entropy bit from trng_core.
REQ-008 SHALL have port in_valid  input  1  in_bit is sampled only when this is high.
REQ-009 SHALL have port clear_fail  input  1  one-cycle pulse that leaves FAIL.
REQ-010 SHALL have port out_bit  output  1  health-checked bit, sent to the von Neumann corrector.
REQ-011 SHALL have port out_valid  output  1  out_bit is valid this cycle.
REQ-012 SHALL have port healthy  output  1  high only while in RUN.
REQ-013 SHALL have port fail_code  output  2  01 = RCT failure, 10 = APT failure, 11 = both failed on the same bit, 00 = no failure.

Function
REQ-014 SHALL implement a state machine with three states: STARTUP, RUN and FAIL.
REQ-015 SHALL advance the counters, the last-bit register and the window only on cycles where in_valid is 1.
REQ-016 RCT: the first valid bit after reset or restart SHALL set last=in_bit and run=1.
REQ-017 RCT: each later valid bit SHALL increment run if it equals last, otherwise set run=1 and last=in_bit.
REQ-018 RCT: SHALL flag failure on the valid bit where run reaches RCT_CUTOFF.
REQ-019 APT: the first bit of each window SHALL become the reference, with match=1.
REQ-020 APT: each later bit in the window equal to the reference SHALL increment match.
REQ-021 APT: SHALL flag failure on the valid bit where match reaches APT_CUTOFF.
REQ-022 APT: after the APT_WINDOW-th bit of a window, the next valid bit SHALL start a new window.
REQ-023 STARTUP: out_valid SHALL be 0 and both tests SHALL run.
REQ-024 STARTUP: after STARTUP_BITS valid bits with no failure, the state SHALL move to RUN on the following edge.
REQ-025 RUN: for each valid bit, out_bit SHALL equal in_bit and out_valid SHALL be 1 exactly one cycle later.
REQ-026 RUN: when in_valid is 0, out_valid SHALL be 0 on the next cycle.
REQ-027 A failing bit SHALL never be forwarded: out_valid stays 0 for it in every state.
REQ-028 A failure in STARTUP or RUN SHALL move the state to FAIL on the same edge, with fail_code latched.
REQ-029 FAIL SHALL be sticky: out_valid=0, healthy=0, fail_code held, in_bit ignored.
REQ-030 clear_fail in FAIL SHALL move the state to STARTUP, clear all counters and the startup count, and set fail_code=00.
REQ-031 clear_fail in STARTUP or RUN SHALL be ignored.
REQ-032 All counters SHALL saturate and never wrap.
REQ-033 Counter widths SHALL be ceil(log2(parameter))+1 bits.

Reset
REQ-034 While rstn is 1 at a clock edge, the next state SHALL be STARTUP and all counters and the startup count SHALL clear.
REQ-035 While rstn is 1 at a clock edge, out_bit=0, out_valid=0, healthy=0 and fail_code=00.
REQ-036 rstn SHALL take priority over clear_fail, in_valid and any failure in the same cycle, including reset asserted mid-RUN or mid-FAIL.

Configuration
REQ-037 When macro TRNG_HEALTH_APT_EN is defined, the APT logic SHALL be compiled in and fail_code[1] SHALL be functional.
REQ-038 When TRNG_HEALTH_APT_EN is undefined, no APT logic SHALL exist, fail_code[1] SHALL be tied to 0, and only RCT can cause FAIL.

Verification
REQ-039 Reset, then alternating 0,1 with in_valid=1 continuously -> healthy=1 one cycle after the 128th bit; afterwards out_bit equals in_bit delayed 1 cycle, with out_valid=1.
REQ-040 In RUN, feed eight consecutive 1s -> no out_valid for the 8th bit, FAIL entered, fail_code=01, healthy=0.
REQ-041 With TRNG_HEALTH_APT_EN, in RUN at a window start, repeat the pattern 1,1,1,0 -> fail_code=10 on the 63rd window bit; without the macro, no failure.
REQ-042 In FAIL, pulse clear_fail -> STARTUP the next cycle, fail_code=00, and 128 clean bits are needed again before healthy=1.
REQ-043 In RUN, hold in_valid=0 for 5 cycles with in_bit=1 -> counters unchanged, out_valid=0, no failure.
REQ-044 Assert rstn together with clear_fail and a failing bit -> STARTUP, fail_code=00, all outputs 0.

Source files
------------

// File: rtl/trng_health_mon.sv
// ============================================================================
//  Module      : trng_health_mon
//  Description : Online health monitor for a raw TRNG bit stream. Runs a
//                repetition-count test (RCT) and, optionally, an
//                adaptive-proportion test (APT) on every valid input bit.
//                Bits are forwarded one cycle later only while the monitor
//                is in RUN and the bit itself did not trip a test.
//  Options     : `define TRNG_HEALTH_APT_EN to build in the APT logic;
//                without it fail_code[1] is tied to 0 and only RCT can fail.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1  clock, all logic on rising edge
//    rstn        in   1  synchronous reset, ACTIVE HIGH despite the name
//    in_bit      in   1  raw entropy bit
//    in_valid    in   1  in_bit qualifier
//    clear_fail  in   1  pulse that leaves FAIL (ignored elsewhere)
//    out_bit     out  1  health-checked bit
//    out_valid   out  1  out_bit qualifier
//    healthy     out  1  high only while in RUN
//    fail_code   out  2  01 RCT, 10 APT, 11 both, 00 none
// ============================================================================
`default_nettype none

module trng_health_mon #(
  parameter int RCT_CUTOFF   = 8,
  parameter int APT_WINDOW   = 64,
  parameter int APT_CUTOFF   = 48,
  parameter int STARTUP_BITS = 128
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       clear_fail,
  output logic       out_bit,
  output logic       out_valid,
  output logic       healthy,
  output logic [1:0] fail_code
);

  localparam int RCT_W   = $clog2(RCT_CUTOFF) + 1;
  localparam int START_W = $clog2(STARTUP_BITS) + 1;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAIL    = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_out_bit;
  logic               r_out_valid;
  logic               r_healthy;
  logic [1:0]         r_fail_code;
  logic [START_W-1:0] r_start_cnt;
  logic [START_W-1:0] w_start_nxt;

  // Test counters advance on every valid bit outside FAIL and restart on
  // reset or on a clear from FAIL.
  logic w_cnt_adv;
  logic w_cnt_clr;
  assign w_cnt_adv = in_valid && (r_state != ST_FAIL);
  assign w_cnt_clr = rstn || ((r_state == ST_FAIL) && clear_fail);

  // --------------------------------------------------------------------------
  // Repetition-count test. A run count of zero marks "no bit seen yet", so
  // the first bit after a restart always starts a fresh run of one.
  // --------------------------------------------------------------------------
  logic [RCT_W-1:0] r_rct_run;
  logic [RCT_W-1:0] w_rct_run_nxt;
  logic             r_last;
  logic             w_rct_fail;

  always_comb begin
    w_rct_run_nxt = RCT_W'(1);
    if ((r_rct_run != '0) && (in_bit == r_last)) begin
      if (r_rct_run < RCT_W'(RCT_CUTOFF))
        w_rct_run_nxt = r_rct_run + RCT_W'(1);
      else
        w_rct_run_nxt = r_rct_run;
    end
    w_rct_fail = (w_rct_run_nxt >= RCT_W'(RCT_CUTOFF));
  end

  always_ff @(posedge clk) begin
    if (w_cnt_clr) begin
      r_rct_run <= '0;
      r_last    <= 1'b0;
    end else if (w_cnt_adv) begin
      r_rct_run <= w_rct_run_nxt;
      r_last    <= in_bit;
    end
  end

  // --------------------------------------------------------------------------
  // Adaptive-proportion test. A window count of zero (after restart) or of
  // APT_WINDOW (window complete) makes the incoming bit the new reference.
  // --------------------------------------------------------------------------
  logic w_apt_fail;

`ifdef TRNG_HEALTH_APT_EN
  localparam int WIN_W = $clog2(APT_WINDOW) + 1;
  localparam int MAT_W = $clog2(APT_CUTOFF) + 1;

  logic [WIN_W-1:0] r_apt_win;
  logic [WIN_W-1:0] w_apt_win_nxt;
  logic [MAT_W-1:0] r_apt_match;
  logic [MAT_W-1:0] w_apt_match_nxt;
  logic             r_apt_ref;
  logic             w_apt_ref_nxt;

  always_comb begin
    w_apt_win_nxt   = WIN_W'(1);
    w_apt_match_nxt = MAT_W'(1);
    w_apt_ref_nxt   = in_bit;
    if ((r_apt_win != '0) && (r_apt_win < WIN_W'(APT_WINDOW))) begin
      w_apt_win_nxt   = r_apt_win + WIN_W'(1);
      w_apt_ref_nxt   = r_apt_ref;
      w_apt_match_nxt = r_apt_match;
      if ((in_bit == r_apt_ref) && (r_apt_match < MAT_W'(APT_CUTOFF)))
        w_apt_match_nxt = r_apt_match + MAT_W'(1);
    end
    w_apt_fail = (w_apt_match_nxt >= MAT_W'(APT_CUTOFF));
  end

  always_ff @(posedge clk) begin
    if (w_cnt_clr) begin
      r_apt_win   <= '0;
      r_apt_match <= '0;
      r_apt_ref   <= 1'b0;
    end else if (w_cnt_adv) begin
      r_apt_win   <= w_apt_win_nxt;
      r_apt_match <= w_apt_match_nxt;
      r_apt_ref   <= w_apt_ref_nxt;
    end
  end
`else
  assign w_apt_fail = 1'b0;
`endif

  // Saturating startup bit count.
  always_comb begin
    w_start_nxt = r_start_cnt;
    if (r_start_cnt < START_W'(STARTUP_BITS))
      w_start_nxt = r_start_cnt + START_W'(1);
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs. A failing bit moves to FAIL on the
  // edge that samples it and is never forwarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state     <= ST_STARTUP;
      r_start_cnt <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_healthy   <= 1'b0;
      r_fail_code <= 2'b00;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_STARTUP, ST_RUN: begin
          if (in_valid) begin
            if (w_rct_fail || w_apt_fail) begin
              r_state     <= ST_FAIL;
              r_healthy   <= 1'b0;
              r_fail_code <= {w_apt_fail, w_rct_fail};
            end else if (r_state == ST_RUN) begin
              r_out_bit   <= in_bit;
              r_out_valid <= 1'b1;
            end else begin
              r_start_cnt <= w_start_nxt;
              if (w_start_nxt == START_W'(STARTUP_BITS)) begin
                r_state   <= ST_RUN;
                r_healthy <= 1'b1;
              end
            end
          end
        end
        ST_FAIL: begin
          if (clear_fail) begin
            r_state     <= ST_STARTUP;
            r_start_cnt <= '0;
            r_fail_code <= 2'b00;
          end
        end
        default: begin
          r_state   <= ST_STARTUP;
          r_healthy <= 1'b0;
        end
      endcase
    end
  end

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign healthy   = r_healthy;
  assign fail_code = r_fail_code;

endmodule

`default_nettype wire
